// File: rtl/alu_exec_stage.sv
// alu_exec_stage: single-issue ALU execute stage with valid/ready handshakes.
// Iterative shifts run one bit per cycle in the SHIFT state. Defining ALU_BARREL_SHIFT_EN
// makes them single-cycle like every other op, so the SHIFT state is never entered.
module alu_exec_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [RAW-1:0]  rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [RAW-1:0]  out_rd,
    output logic            out_err
);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpSlt  = 4'd5;
    localparam logic [3:0] OpSltu = 4'd6;
    localparam logic [3:0] OpSll  = 4'd7;
    localparam logic [3:0] OpSrl  = 4'd8;
    localparam logic [3:0] OpSra  = 4'd9;

    typedef enum logic [1:0] {StIdle, StShift, StOut} state_e;

    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_result, w_result_nxt;
    logic [RAW-1:0]  r_rd, w_rd_nxt;
    logic            r_err, w_err_nxt;
    logic [4:0]      r_cnt, w_cnt_nxt;
    logic [3:0]      r_op, w_op_nxt;

    logic            w_accept;
    logic            w_load;
    logic            w_illegal;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_step;

    assign w_shamt   = rs2_data[4:0];
    assign in_ready  = rst_n && ((r_state == StIdle) || ((r_state == StOut) && out_ready));
    assign w_accept  = in_valid && in_ready;

    assign out_valid = (r_state == StOut);
    assign result    = r_result;
    assign out_rd    = r_rd;
    assign out_err   = r_err;

    // Single-cycle result for the incoming bundle; iterative shifts start from rs1_data.
    always_comb begin
        w_alu     = '0;
        w_illegal = 1'b0;
        case (op)
            OpAdd:  w_alu = rs1_data + rs2_data;
            OpSub:  w_alu = rs1_data - rs2_data;
            OpAnd:  w_alu = rs1_data & rs2_data;
            OpOr:   w_alu = rs1_data | rs2_data;
            OpXor:  w_alu = rs1_data ^ rs2_data;
            OpSlt:  w_alu = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(rs2_data))};
            OpSltu: w_alu = {{(XLEN-1){1'b0}}, (rs1_data < rs2_data)};
`ifdef ALU_BARREL_SHIFT_EN
            OpSll:  w_alu = rs1_data << w_shamt;
            OpSrl:  w_alu = rs1_data >> w_shamt;
            OpSra:  w_alu = $unsigned($signed(rs1_data) >>> w_shamt);
`else
            OpSll, OpSrl, OpSra: w_alu = rs1_data;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    // One bit position of the pending iterative shift; SRA re-inserts the held sign bit.
    always_comb begin
        case (r_op)
            OpSll:   w_step = {r_result[XLEN-2:0], 1'b0};
            OpSrl:   w_step = {1'b0, r_result[XLEN-1:1]};
            default: w_step = {r_result[XLEN-1], r_result[XLEN-1:1]};
        endcase
    end

    // Next-state logic: accept from IDLE or from OUT when the output is drained this cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_rd_nxt     = r_rd;
        w_err_nxt    = r_err;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_load       = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_accept) w_load = 1'b1;
            end
            StShift: begin
                w_result_nxt = w_step;
                w_cnt_nxt    = r_cnt - 5'd1;
                if (r_cnt == 5'd1) w_state_nxt = StOut;
            end
            StOut: begin
                // w_accept already implies out_ready here
                if (w_accept) begin
                    w_load = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        if (w_load) begin
            w_result_nxt = w_alu;
            w_rd_nxt     = rd;
            w_err_nxt    = w_illegal;
            w_op_nxt     = op;
            w_state_nxt  = StOut;
            w_cnt_nxt    = '0;
`ifndef ALU_BARREL_SHIFT_EN
            if (((op == OpSll) || (op == OpSrl) || (op == OpSra)) && (w_shamt != 5'd0)) begin
                w_state_nxt = StShift;
                w_cnt_nxt   = w_shamt;
            end
`endif
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_result <= '0;
            r_rd     <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_op     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_rd     <= w_rd_nxt;
            r_err    <= w_err_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op     <= w_op_nxt;
        end
    end

endmodule
